// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared UART line constants, common to the receiver and the FIFO-fed
// transmitter. It holds the default clock and baud values and the
// clocks-per-bit derivation, so both directions compute the bit period
// the same way.
package uart_rx_pkg;

  localparam logic [31:0] DEFAULT_CLOCK_FREQUENCY = 32'd100_000_000;
  localparam logic [31:0] DEFAULT_BAUD_RATE       = 32'd115200;

  // Integer division: the bit period is truncated, never rounded up.
  function automatic logic [31:0] clocks_per_bit(input logic [31:0] clock_frequency,
                                                 input logic [31:0] baud_rate);
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for one asynchronous input. The reset value is a
// parameter so that idle-high lines, such as a UART rx pin, come out of
// reset in their idle level.
// Ports:
//   clk - sampling clock
//   rst - synchronous, active-high reset
//   d   - asynchronous input
//   q   - synchronized output, two clk cycles behind d
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= RESET_VALUE;
      sync_p1 <= RESET_VALUE;
    end else begin
      // stage p0: first capture of the asynchronous input
      sync_p0 <= d;
      // stage p1: metastability settled
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// UART receiver (1 start bit, WORD_WIDTH data bits LSB first, 1 stop bit,
// no parity). The line is synchronized, each bit is sampled at its centre,
// and a good word is written to a downstream FIFO with a one-cycle we pulse.
// Ports:
//   clk         - system clock
//   rst         - synchronous, active-high reset
//   din         - asynchronous serial line, idle high
//   full        - downstream FIFO full, looked at only on the stop-bit sample
//   dout        - last received word, held between writes
//   we          - one-cycle FIFO write pulse per accepted word
//   frame_error - one-cycle pulse when the stop bit samples 0
//   overrun     - one-cycle pulse when a good word is dropped because full=1
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter logic [31:0] CLOCK_FREQUENCY = DEFAULT_CLOCK_FREQUENCY,
  parameter logic [31:0] BAUD_RATE       = DEFAULT_BAUD_RATE,
  parameter logic [31:0] WORD_WIDTH      = 32'd8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din,
  input  logic                  full,
  output logic [WORD_WIDTH-1:0] dout,
  output logic                  we,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam logic [31:0] CLOCKS_PER_BIT = clocks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam logic [31:0] HALF_BIT       = CLOCKS_PER_BIT / 32'd2;
  localparam int          IDX_W          = $clog2(WORD_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_WIDTH - 1);

  generate
    if (CLOCKS_PER_BIT < 32'd4) begin : g_bad_rate
      $error("uart_rx: CLOCK_FREQUENCY / BAUD_RATE must be at least 4");
    end
    if (WORD_WIDTH < 32'd2) begin : g_bad_width
      $error("uart_rx: WORD_WIDTH must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t                state;
  logic [31:0]           cnt;
  logic [IDX_W-1:0]      idx;
  logic [WORD_WIDTH-1:0] shreg;
  logic                  rx_s;

  // stage p0/p1: din synchronized, idle-high out of reset
  sync_2ff #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (din),
    .q  (rx_s)
  );

  // stage p2: frame FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      dout        <= '0;
      we          <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      we          <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          // Re-check the start bit at its centre; a high line here was a glitch.
          if (cnt == HALF_BIT - 32'd1) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        DATA: begin
          if (cnt == CLOCKS_PER_BIT - 32'd1) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[WORD_WIDTH-1:1]};
            idx   <= idx + IDX_W'(1);
            if (idx == LAST_IDX) state <= STOP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        STOP: begin
          // Leaving at the stop-bit centre leaves half a bit to catch an
          // immediately following start edge.
          if (cnt == CLOCKS_PER_BIT - 32'd1) begin
            cnt <= '0;
            if (rx_s) begin
              if (!full) begin
                dout <= shreg;
                we   <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state <= IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        WAIT_IDLE: begin
          // A held break produces one frame_error, not one per bit time.
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPB = 10;
  localparam int LAT_MIN = 98;  // 9.5 bits of 10 clk plus 3..4 clk
  localparam int LAT_MAX = 99;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b1;
  logic       full = 1'b0;
  logic [7:0] dout;
  logic       we;
  logic       frame_error;
  logic       overrun;

  uart_rx #(
    .CLOCK_FREQUENCY(32'd1_000_000),
    .BAUD_RATE      (32'd100_000),
    .WORD_WIDTH     (32'd8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .full       (full),
    .dout       (dout),
    .we         (we),
    .frame_error(frame_error),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log of everything the receiver reports.
  logic [7:0]  got_q[$];
  int unsigned got_cyc[$];
  int          fe_cnt = 0;
  int          ov_cnt = 0;
  int          multi_cnt = 0;
  int          we_dout_bad = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (we) begin
        got_q.push_back(dout);
        got_cyc.push_back(cyc);
      end
      if (frame_error) fe_cnt++;
      if (overrun) ov_cnt++;
      if ((int'(we) + int'(frame_error) + int'(overrun)) > 1) multi_cnt++;
    end
  end

  // Reference: last word the model expects on dout.
  logic [7:0] model_dout = 8'h00;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    din = v;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] w, input logic stop_bit, output int unsigned t0);
    t0 = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
    send_bit(stop_bit);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = 1'b1;
    tick(3);
    vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout got=%h exp=00", dout); end
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL reset_we got=%b exp=0", we); end
    vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL reset_fe got=%b exp=0", frame_error); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_ov got=%b exp=0", overrun); end
    rst = 1'b0;
    tick(2 * CPB);
    model_dout = 8'h00;
  endtask

  task automatic test_back_to_back();
    int b, f, o;
    int unsigned t0, t1, lat;
    b = got_q.size(); f = fe_cnt; o = ov_cnt;
    send_frame(8'h55, 1'b1, t0);
    send_frame(8'hA3, 1'b1, t1);
    din = 1'b1;
    tick(2 * CPB);
    vectors++;
    if (got_q.size() - b != 2) begin
      miscompares++; $display("FAIL b2b_count got=%0d exp=2", got_q.size() - b);
    end else begin
      vectors++; if (got_q[b] !== 8'h55) begin miscompares++; $display("FAIL b2b_word0 got=%h exp=55", got_q[b]); end
      vectors++; if (got_q[b+1] !== 8'hA3) begin miscompares++; $display("FAIL b2b_word1 got=%h exp=a3", got_q[b+1]); end
      lat = got_cyc[b] - t0;
      vectors++; if (lat < LAT_MIN || lat > LAT_MAX) begin miscompares++; $display("FAIL b2b_lat0 got=%0d exp=%0d..%0d", lat, LAT_MIN, LAT_MAX); end
      lat = got_cyc[b+1] - t1;
      vectors++; if (lat < LAT_MIN || lat > LAT_MAX) begin miscompares++; $display("FAIL b2b_lat1 got=%0d exp=%0d..%0d", lat, LAT_MIN, LAT_MAX); end
    end
    vectors++; if (fe_cnt - f + ov_cnt - o != 0) begin miscompares++; $display("FAIL b2b_errors got=%0d exp=0", fe_cnt - f + ov_cnt - o); end
    model_dout = 8'hA3;
    vectors++; if (dout !== model_dout) begin miscompares++; $display("FAIL b2b_dout_hold got=%h exp=%h", dout, model_dout); end
  endtask

  task automatic test_glitch();
    int b, f, o;
    int unsigned t0;
    b = got_q.size(); f = fe_cnt; o = ov_cnt;
    din = 1'b0;
    tick(3);
    din = 1'b1;
    tick(3 * CPB);
    vectors++; if (got_q.size() != b || fe_cnt != f || ov_cnt != o) begin
      miscompares++; $display("FAIL glitch_events got we=%0d fe=%0d ov=%0d exp=0", got_q.size() - b, fe_cnt - f, ov_cnt - o);
    end
    send_frame(8'h5A, 1'b1, t0);
    din = 1'b1; tick(CPB);
    model_dout = 8'h5A;
    vectors++; if (got_q.size() != b + 1 || dout !== model_dout) begin
      miscompares++; $display("FAIL glitch_recover got n=%0d dout=%h exp n=1 dout=%h", got_q.size() - b, dout, model_dout);
    end
  endtask

  task automatic test_break();
    int b, f, o;
    int unsigned t0;
    b = got_q.size(); f = fe_cnt; o = ov_cnt;
    send_frame(8'h3C, 1'b0, t0);
    din = 1'b0;
    tick(30 * CPB);
    din = 1'b1;
    tick(2 * CPB);
    vectors++; if (fe_cnt - f != 1) begin miscompares++; $display("FAIL break_fe got=%0d exp=1", fe_cnt - f); end
    vectors++; if (got_q.size() != b || ov_cnt != o) begin miscompares++; $display("FAIL break_nowrite got we=%0d ov=%0d exp=0", got_q.size() - b, ov_cnt - o); end
    vectors++; if (dout !== model_dout) begin miscompares++; $display("FAIL break_dout got=%h exp=%h", dout, model_dout); end
    send_frame(8'h81, 1'b1, t0);
    din = 1'b1; tick(CPB);
    model_dout = 8'h81;
    vectors++; if (got_q.size() != b + 1 || dout !== model_dout) begin
      miscompares++; $display("FAIL break_next got n=%0d dout=%h exp n=1 dout=%h", got_q.size() - b, dout, model_dout);
    end
  endtask

  task automatic test_overrun();
    int b, f, o;
    int unsigned t0;
    b = got_q.size(); f = fe_cnt; o = ov_cnt;
    full = 1'b1;
    send_frame(8'h7E, 1'b1, t0);
    din = 1'b1; tick(CPB);
    vectors++; if (ov_cnt - o != 1) begin miscompares++; $display("FAIL ovr_pulse got=%0d exp=1", ov_cnt - o); end
    vectors++; if (got_q.size() != b || fe_cnt != f) begin miscompares++; $display("FAIL ovr_nowrite got we=%0d fe=%0d exp=0", got_q.size() - b, fe_cnt - f); end
    vectors++; if (dout !== model_dout) begin miscompares++; $display("FAIL ovr_dout got=%h exp=%h", dout, model_dout); end
    full = 1'b0;
    send_frame(8'h7E, 1'b1, t0);
    din = 1'b1; tick(CPB);
    model_dout = 8'h7E;
    vectors++; if (got_q.size() != b + 1 || dout !== model_dout) begin
      miscompares++; $display("FAIL ovr_after got n=%0d dout=%h exp n=1 dout=%h", got_q.size() - b, dout, model_dout);
    end
  endtask

  task automatic test_reset_abort();
    int b, f, o;
    int unsigned t0;
    b = got_q.size(); f = fe_cnt; o = ov_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    din = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_dout = 8'h00;
    vectors++; if (dout !== 8'h00 || we !== 1'b0) begin miscompares++; $display("FAIL abort_reset got dout=%h we=%b exp 00/0", dout, we); end
    tick(2 * CPB);
    send_frame(8'h12, 1'b1, t0);
    din = 1'b1; tick(CPB);
    model_dout = 8'h12;
    vectors++; if (got_q.size() != b + 1) begin
      miscompares++; $display("FAIL abort_count got=%0d exp=1", got_q.size() - b);
    end else begin
      vectors++; if (got_q[b] !== 8'h12) begin miscompares++; $display("FAIL abort_word got=%h exp=12", got_q[b]); end
    end
    vectors++; if (fe_cnt != f || ov_cnt != o) begin miscompares++; $display("FAIL abort_errors got fe=%0d ov=%0d exp=0", fe_cnt - f, ov_cnt - o); end
  endtask

  // Random frames: random word, random full, occasional bad stop bit, random gap.
  task automatic test_random(input int n);
    logic [7:0] exp_q[$];
    int b, f, o, fe_exp, ov_exp, gap, bad;
    logic [7:0] w;
    logic stop_bit;
    int unsigned t0;
    b = got_q.size(); f = fe_cnt; o = ov_cnt;
    fe_exp = 0; ov_exp = 0;
    for (int k = 0; k < n; k++) begin
      w        = 8'($urandom);
      full     = ($urandom_range(0, 3) == 0);
      stop_bit = ($urandom_range(0, 7) != 0);
      if (!stop_bit) fe_exp++;
      else if (full) ov_exp++;
      else begin exp_q.push_back(w); model_dout = w; end
      send_frame(w, stop_bit, t0);
      gap = $urandom_range(0, 2);
      if (!stop_bit && gap == 0) gap = 1;
      din = 1'b1;
      if (gap > 0) tick(gap * CPB);
    end
    full = 1'b0;
    din = 1'b1; tick(2 * CPB);
    vectors++;
    if (got_q.size() - b != exp_q.size()) begin
      miscompares++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size() - b, exp_q.size());
    end else begin
      bad = 0;
      for (int k = 0; k < exp_q.size(); k++) if (got_q[b+k] !== exp_q[k]) bad++;
      if (bad != 0) begin miscompares++; $display("FAIL rand_words got=%0d wrong exp=0 wrong", bad); end
    end
    vectors++; if (fe_cnt - f != fe_exp) begin miscompares++; $display("FAIL rand_fe got=%0d exp=%0d", fe_cnt - f, fe_exp); end
    vectors++; if (ov_cnt - o != ov_exp) begin miscompares++; $display("FAIL rand_ov got=%0d exp=%0d", ov_cnt - o, ov_exp); end
    vectors++; if (dout !== model_dout) begin miscompares++; $display("FAIL rand_dout got=%h exp=%h", dout, model_dout); end
  endtask

  // Transmitter stand-in: 0x00..0xFF serialized with random 0..1 bit gaps.
  task automatic test_loopback();
    int b, f, o, bad, first_bad;
    int unsigned t0;
    b = got_q.size(); f = fe_cnt; o = ov_cnt;
    for (int k = 0; k < 256; k++) begin
      send_frame(8'(k), 1'b1, t0);
      din = 1'b1;
      if ($urandom_range(0, 1) == 1) tick(CPB);
    end
    din = 1'b1; tick(2 * CPB);
    model_dout = 8'hFF;
    vectors++;
    if (got_q.size() - b != 256) begin
      miscompares++; $display("FAIL loop_count got=%0d exp=256", got_q.size() - b);
    end else begin
      bad = 0; first_bad = -1;
      for (int k = 0; k < 256; k++) if (got_q[b+k] !== 8'(k)) begin bad++; if (first_bad < 0) first_bad = k; end
      if (bad != 0) begin miscompares++; $display("FAIL loop_words got=%0d wrong (first at %0d) exp=0", bad, first_bad); end
    end
    vectors++; if (fe_cnt != f || ov_cnt != o) begin miscompares++; $display("FAIL loop_errors got fe=%0d ov=%0d exp=0", fe_cnt - f, ov_cnt - o); end
  endtask

  task automatic test_exclusive();
    vectors++; if (multi_cnt != 0) begin miscompares++; $display("FAIL exclusive_pulses got=%0d exp=0", multi_cnt); end
  endtask

  initial begin
    #1;
    test_reset();
    test_back_to_back();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_abort();
    test_random(40);
    test_loopback();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
